serial_link_tx_arb: RTL

- Round-robin arbiter and serializer that shares one serial link between N_REQ local requesters.
- Drives the serial input of a link receiver (dclk_rx) in the write-clock domain; clk is that receiver's wclk.
- Takes parallel items, grants one requester at a time, and emits the framed bit stream that dclk_rx expects.
- Uses the receiver's channel_busy as flow control, so a new frame starts only after the previous item has been read.

---
 rtl/serial_link_tx_arb.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/serial_link_tx_arb.sv
// -----------------------------------------------------------------------------
// serial_link_tx_arb
//
// Round-robin arbiter and serializer. It shares one serial link between N_REQ
// local requesters and drives the serial input of a link receiver whose write
// clock is clk. A granted item is sent as a framed bit stream, LSB first:
//   start bit (1), ITEM_SZ data bits, guard bit (0).
// The next frame starts only after the receiver's busy flag has been seen high
// and then low again, which means the previous item has been read.
//
// Ports
//   clk           link clock (receiver wclk); all logic on posedge
//   reset         asynchronous, active-low reset
//   req           per-requester item-available level
//   data_in       item of requester i at bits [i*ITEM_SZ +: ITEM_SZ]
//   ack           one-hot, one-cycle pulse: requester i's item was captured
//   channel_busy  receiver busy flag, asynchronous to clk
//   serial_out    serial data to the receiver's serial_in
//   link_busy     high whenever a frame is being sent or awaiting read-out
// -----------------------------------------------------------------------------
module serial_link_tx_arb #(
  parameter int N_REQ   = 4,
  parameter int ITEM_SZ = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*ITEM_SZ-1:0]   data_in,
  output logic [N_REQ-1:0]           ack,
  input  logic                       channel_busy,
  output logic                       serial_out,
  output logic                       link_busy
);

  localparam int FRAME_SZ = ITEM_SZ + 2;
  localparam int CNT_W    = $clog2(FRAME_SZ);
  localparam int RR_W     = $clog2(N_REQ);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_SZ - 1);
  localparam logic [RR_W-1:0]  RR_INIT  = RR_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t              r_state;
  logic [FRAME_SZ-1:0] r_shreg;
  logic [CNT_W-1:0]    r_cnt;
  logic [RR_W-1:0]     r_rr;
  logic                r_seen_busy;
  logic [1:0]          r_sync;
  logic [N_REQ-1:0]    r_ack;

  logic                w_busy_s;
  logic                w_found;
  logic [RR_W-1:0]     w_winner;
  logic [ITEM_SZ-1:0]  w_item;

  // Only the synchronized busy flag is ever used for decisions.
  assign w_busy_s = r_sync[1];

  // Requester index k positions after base, wrapping at N_REQ (which need not
  // be a power of two).
  function automatic logic [RR_W-1:0] rr_idx(input logic [RR_W-1:0] base,
                                             input int k);
    int sum;
    sum = (int'(base) + k) % N_REQ;
    return RR_W'(sum);
  endfunction

  // Round-robin scan starting just after the last winner; the last winner
  // itself is checked last, which bounds the wait of any held request to
  // N_REQ frames.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_rr;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!w_found && req[rr_idx(r_rr, k)]) begin
        w_found  = 1'b1;
        w_winner = rr_idx(r_rr, k);
      end
    end
  end

  assign w_item = data_in[int'(w_winner)*ITEM_SZ +: ITEM_SZ];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_rr        <= RR_INIT;
      r_seen_busy <= 1'b0;
      r_sync      <= '0;
      r_ack       <= '0;
    end else begin
      r_sync <= {r_sync[0], channel_busy};
      r_ack  <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found && !w_busy_s) begin
            // Whole frame is loaded at once so data_in is only sampled here.
            r_shreg     <= {1'b0, w_item, 1'b1};
            r_ack       <= ONE_HOT0 << w_winner;
            r_rr        <= w_winner;
            r_cnt       <= '0;
            r_seen_busy <= 1'b0;
            r_state     <= S_SEND;
          end
        end
        S_SEND: begin
          r_shreg <= {1'b0, r_shreg[FRAME_SZ-1:1]};
          r_cnt   <= r_cnt + 1'b1;
          // The guard bit is on the line while cnt == LAST_BIT; shifting it
          // out leaves the register all zeros, so serial_out idles low.
          if (r_cnt == LAST_BIT) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Wait for a full busy pulse from the receiver: it must have
          // accepted the item and then had it read before the next start bit.
          r_seen_busy <= r_seen_busy | w_busy_s;
          if (r_seen_busy && !w_busy_s) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign serial_out = r_shreg[0];
  assign ack        = r_ack;
  assign link_busy  = (r_state != S_IDLE);

endmodule
